seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
Parametrised multiplexed driver for an N-digit common-anode seven-segment display. It holds a double-buffered BCD/hex frame and time-multiplexes digits via a prescaled scan counter. It decodes each digit to active-low cathodes and adds decimal points, leading-zero blanking, anode guard time and a global blank. It sits between the display-value producers and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
CLK_DIV, 50000, clock cycles per digit slot (must be > GUARD+1)
GUARD, 2, cycles all anodes are held off after each digit switch (anti-ghosting)
LZ_BLANK, 1, 1 = blank leading zeros, 0 = show all digits

Ports:
clock  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
digits  input  4*NUM_DIGITS  digit values; digit i = digits[4i+3:4i]; digit 0 least significant
dp  input  NUM_DIGITS  decimal point request per digit, 1 = lit
load  input  1  one-cycle strobe; captures digits/dp
blank  input  1  1 = all anodes off; scanning continues
cathodes  output  7  {a,b,c,d,e,f,g}, active-low (0 = segment lit)
dp_out  output  1  decimal point segment, active-low
anodes  output  NUM_DIGITS  digit enables, active-low; bit i drives digit i
frame_done  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0

Behaviour:
- Clock and reset: single clock "clock"; reset "resetn" is synchronous and active-low. All state changes occur on the rising edge.
- Reset values (next edge with resetn=0):
  - anodes all 1, cathodes 7'b1111111, dp_out 1, frame_done 0.
  - Prescaler 0, scan index 0, guard count 0.
  - Shadow and pending buffers 0; pending flag clear.
  - Reset mid-scan aborts immediately. An uncommitted load is discarded.
- Prescaler: counts 0..CLK_DIV-1 and wraps. "tick" = prescaler at CLK_DIV-1.
- Scan index:
  - On tick, index <= (index==NUM_DIGITS-1) ? 0 : index+1, and guard count <= GUARD.
  - Otherwise the guard count decrements to 0.
- Wrap: a tick with index==NUM_DIGITS-1. frame_done is 1 in the cycle after the wrap tick only.
- Double buffering:
  - load=1 captures digits/dp into the pending buffer and sets the pending flag. A later load before commit overwrites it (latest wins).
  - On a wrap tick with pending set, shadow <= pending and pending clears.
  - load and wrap tick in the same cycle: input goes directly to shadow and pending stays clear.
  - The displayed frame never changes mid-scan.
- Decode of the shadow digit at the current index (registered; outputs reflect the new index 1 cycle after tick):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - 10..15 = dash 1111110.
- dp_out = ~shadow_dp[index].
- Leading-zero blanking (LZ_BLANK=1):
  - Digit i>0 is blanked if it and every more-significant digit are 0 and their dp bits are 0.
  - Digit 0 is never blanked.
  - Blanked digit: cathodes 1111111, dp_out 1; its anode still cycles (uniform duty).
- Anodes:
  - All 1 while guard count != 0 (cycles T+1..T+GUARD after tick at T) or blank=1.
  - Otherwise only bit index = 0.
  - blank takes effect on the next edge.
- Widths: prescaler $clog2(CLK_DIV) bits; index $clog2(NUM_DIGITS) bits (min 1); no truncation of index at wrap.

Test Plan:
(All with NUM_DIGITS=4, CLK_DIV=4, GUARD=1, LZ_BLANK=1.)
1. Reset: resetn=0 for 3 cycles, then release -> anodes 1111, cathodes 1111111, dp_out 1, frame_done 0 while held. After release, scan shows digit 0 = 0000001 on anode 1110, digits 1-3 blanked.
2. Load 16'h1234, dp=0 -> after next frame_done, each slot (after 1 guard cycle of 1111) shows:
   - 1110/1001100
   - 1101/0000110
   - 1011/0010010
   - 0111/1001111
   frame_done is high for exactly 1 cycle per 16.
3. Load 16'h0050 -> digits 3,2 cathodes 1111111 with anodes still cycling; digit1 0100100, digit0 0000001.
   Load 16'h0A00 -> digit3 blank, digit2 1111110, digits 1,0 0000001.
   Load 16'h0000 with dp=4'b0100 -> digit2 0000001 with dp_out 0, digit1 0000001.
4. Buffering:
   - load 16'h1111 at index 1, then 16'h2222 at index 2 -> old frame until wrap; then 2222; 1111 never displayed.
   - load coincident with wrap tick -> new value on the very next slot.
5. blank=1 mid-slot -> anodes 1111 next cycle while index/frame_done keep advancing. blank=0 -> current index anode reasserts next cycle (unless in guard).
6. resetn=0 during digit 2 with pending load -> reset values next edge. After release, scan restarts at index 0 showing shadow 0; the pending value is never displayed.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
// Multiplexed driver for an N-digit common-anode seven-segment display.
// A prescaler sets the per-digit slot length. The displayed frame is
// double-buffered, so a new value only takes effect at a frame boundary.
// Every output is registered. Each output is computed from the next-state
// values, so the outputs follow the new scan index one cycle after a tick.

module seven_segment_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int GUARD      = 2,
    parameter int LZ_BLANK   = 1
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    blank,
    output logic [6:0]              cathodes,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b1111110;

    // Map a nibble to active-low {a,b,c,d,e,f,g}; values above 9 show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    // Scan timing state
    logic [PW-1:0] pre_r;
    logic [IW-1:0] idx_r;
    logic [GW-1:0] guard_r;

    // Frame buffers: shadow is what is shown, pending waits for the next wrap
    logic [NUM_DIGITS-1:0][3:0] shadow_dig_r;
    logic [NUM_DIGITS-1:0]      shadow_dp_r;
    logic [NUM_DIGITS-1:0][3:0] pend_dig_r;
    logic [NUM_DIGITS-1:0]      pend_dp_r;
    logic                       pend_r;

    // Output registers
    logic [6:0]            cath_r;
    logic                  dpo_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic                  fd_r;

    // Next-state values
    logic                       tick_s;
    logic                       wrap_s;
    logic [PW-1:0]              pre_nx_s;
    logic [IW-1:0]              idx_nx_s;
    logic [GW-1:0]              guard_nx_s;
    logic [NUM_DIGITS-1:0][3:0] shadow_dig_nx_s;
    logic [NUM_DIGITS-1:0]      shadow_dp_nx_s;
    logic [NUM_DIGITS-1:0][3:0] pend_dig_nx_s;
    logic [NUM_DIGITS-1:0]      pend_dp_nx_s;
    logic                       pend_nx_s;
    logic [NUM_DIGITS-1:0]      lz_mask_s;
    logic                       zero_run_s;
    logic [6:0]                 cath_nx_s;
    logic                       dpo_nx_s;
    logic [NUM_DIGITS-1:0]      an_nx_s;

    // Prescaler, scan index advance and the post-switch guard countdown
    always_comb begin
        tick_s     = (pre_r == PRE_LAST);
        wrap_s     = tick_s && (idx_r == IDX_LAST);
        pre_nx_s   = pre_r;
        idx_nx_s   = idx_r;
        guard_nx_s = guard_r;
        if (tick_s) begin
            pre_nx_s   = {PW{1'b0}};
            guard_nx_s = GUARD_LOAD;
            if (idx_r == IDX_LAST) begin
                idx_nx_s = {IW{1'b0}};
            end else begin
                idx_nx_s = idx_r + IW'(1);
            end
        end else begin
            pre_nx_s = pre_r + PW'(1);
            if (guard_r != {GW{1'b0}}) begin
                guard_nx_s = guard_r - GW'(1);
            end else begin
                guard_nx_s = guard_r;
            end
        end
    end

    // Double buffering: a load goes to pending, or straight to shadow on a wrap tick
    always_comb begin
        shadow_dig_nx_s = shadow_dig_r;
        shadow_dp_nx_s  = shadow_dp_r;
        pend_dig_nx_s   = pend_dig_r;
        pend_dp_nx_s    = pend_dp_r;
        pend_nx_s       = pend_r;
        if (load && wrap_s) begin
            shadow_dig_nx_s = digits;
            shadow_dp_nx_s  = dp;
            pend_nx_s       = 1'b0;
        end else if (load) begin
            pend_dig_nx_s = digits;
            pend_dp_nx_s  = dp;
            pend_nx_s     = 1'b1;
        end else if (wrap_s && pend_r) begin
            shadow_dig_nx_s = pend_dig_r;
            shadow_dp_nx_s  = pend_dp_r;
            pend_nx_s       = 1'b0;
        end else begin
            pend_nx_s = pend_r;
        end
    end

    // Leading-zero mask: walk down from the most significant digit while
    // every digit seen so far is zero with its decimal point off
    always_comb begin
        lz_mask_s  = {NUM_DIGITS{1'b0}};
        zero_run_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s   = zero_run_s && (shadow_dig_nx_s[i] == 4'd0) && !shadow_dp_nx_s[i];
            lz_mask_s[i] = (i > 0) && (LZ_BLANK != 0) && zero_run_s;
        end
    end

    // Segment, decimal point and anode values for the slot being entered
    always_comb begin
        cath_nx_s = SEG_OFF;
        dpo_nx_s  = 1'b1;
        an_nx_s   = {NUM_DIGITS{1'b1}};
        if (lz_mask_s[idx_nx_s]) begin
            cath_nx_s = SEG_OFF;
            dpo_nx_s  = 1'b1;
        end else begin
            cath_nx_s = seg_decode(shadow_dig_nx_s[idx_nx_s]);
            dpo_nx_s  = ~shadow_dp_nx_s[idx_nx_s];
        end
        if ((guard_nx_s != {GW{1'b0}}) || blank) begin
            an_nx_s = {NUM_DIGITS{1'b1}};
        end else begin
            an_nx_s[idx_nx_s] = 1'b0;
        end
    end

    // Scan and buffer state registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pre_r        <= {PW{1'b0}};
            idx_r        <= {IW{1'b0}};
            guard_r      <= {GW{1'b0}};
            shadow_dig_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_r  <= {NUM_DIGITS{1'b0}};
            pend_dig_r   <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_r       <= 1'b0;
        end else begin
            pre_r        <= pre_nx_s;
            idx_r        <= idx_nx_s;
            guard_r      <= guard_nx_s;
            shadow_dig_r <= shadow_dig_nx_s;
            shadow_dp_r  <= shadow_dp_nx_s;
            pend_dig_r   <= pend_dig_nx_s;
            pend_dp_r    <= pend_dp_nx_s;
            pend_r       <= pend_nx_s;
        end
    end

    // Registered display outputs; frame_done marks the cycle after a wrap tick
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cath_r <= SEG_OFF;
            dpo_r  <= 1'b1;
            an_r   <= {NUM_DIGITS{1'b1}};
            fd_r   <= 1'b0;
        end else begin
            cath_r <= cath_nx_s;
            dpo_r  <= dpo_nx_s;
            an_r   <= an_nx_s;
            fd_r   <= wrap_s;
        end
    end

    assign cathodes   = cath_r;
    assign dp_out     = dpo_r;
    assign anodes     = an_r;
    assign frame_done = fd_r;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (4 digits, 4-cycle slots,
// 1 guard cycle, leading-zero blanking on). The stimulus pushes
// hand-computed expectations. The monitor pops them at each negedge.
// NOW entries describe the outputs in the current cycle. SLOT entries
// describe the next lit digit slot.

module tb_seven_segment_scanner;

    logic        clock;
    logic        resetn;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        load;
    logic        blank;
    logic [6:0]  cathodes;
    logic        dp_out;
    logic [3:0]  anodes;
    logic        frame_done;

    seven_segment_scanner #(
        .NUM_DIGITS(4),
        .CLK_DIV   (4),
        .GUARD     (1),
        .LZ_BLANK  (1)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .digits    (digits),
        .dp        (dp),
        .load      (load),
        .blank     (blank),
        .cathodes  (cathodes),
        .dp_out    (dp_out),
        .anodes    (anodes),
        .frame_done(frame_done)
    );

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SD = 7'b1111110;
    localparam logic [6:0] SB = 7'b1111111;

    localparam logic [1:0] K_NOW  = 2'd0;
    localparam logic [1:0] K_SLOT = 2'd1;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] id;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dpo;
        logic        fd;
        logic        chk_seg;
    } exp_t;

    exp_t exp_q[$];

    // monitor-owned
    int         vectors = 0;
    int         errors  = 0;
    int         cyc     = 0;
    int         last_fd = 0;
    bit         have_fd = 1'b0;
    logic [3:0] prev_an = 4'hF;
    // stimulus-owned
    int         timeouts = 0;
    int         next_id  = 0;
    bit         done     = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_now(input logic [3:0] an, input logic [6:0] seg, input logic dpo,
                            input logic fd, input logic chk_seg);
        exp_t e;
        e.kind = K_NOW; e.id = 16'(next_id); e.an = an; e.seg = seg;
        e.dpo = dpo; e.fd = fd; e.chk_seg = chk_seg;
        next_id++;
        exp_q.push_back(e);
    endtask

    task automatic push_slot(input logic [3:0] an, input logic [6:0] seg, input logic dpo);
        exp_t e;
        e.kind = K_SLOT; e.id = 16'(next_id); e.an = an; e.seg = seg;
        e.dpo = dpo; e.fd = 1'b0; e.chk_seg = 1'b1;
        next_id++;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input logic [3:0] dpo);
        push_slot(4'b1110, s0, dpo[0]);
        push_slot(4'b1101, s1, dpo[1]);
        push_slot(4'b1011, s2, dpo[2]);
        push_slot(4'b0111, s3, dpo[3]);
    endtask

    task automatic load_val(input logic [15:0] d, input logic [3:0] p);
        digits = d;
        dp     = p;
        load   = 1'b1;
        tick(1);
        load   = 1'b0;
    endtask

    // Returns in the cycle where frame_done is high (bounded wait).
    task automatic wait_frame(input bit check_now);
        int n;
        bit got;
        n   = 0;
        got = check_now && (frame_done === 1'b1);
        while (!got && n < 64) begin
            tick(1);
            n++;
            got = (frame_done === 1'b1);
        end
        if (!got) timeouts++;
    endtask

    // Stimulus: directed sequences with hand-computed expectations
    initial begin
        resetn = 1'b0;
        load   = 1'b0;
        blank  = 1'b0;
        digits = 16'h0000;
        dp     = 4'b0000;

        // 1. reset held for 3 edges, then release
        for (int k = 0; k < 3; k++) begin
            tick(1);
            push_now(4'hF, SB, 1'b1, 1'b0, 1'b1);
        end
        resetn = 1'b1;
        tick(1);
        push_now(4'b1110, S0, 1'b1, 1'b0, 1'b1);
        push_slot(4'b1101, SB, 1'b1);
        push_slot(4'b1011, SB, 1'b1);
        push_slot(4'b0111, SB, 1'b1);

        // 2. 1234 with no decimal points, two frames
        load_val(16'h1234, 4'b0000);
        wait_frame(1'b0);
        push_frame(S4, S3, S2, S1, 4'b1111);
        wait_frame(1'b0);
        push_frame(S4, S3, S2, S1, 4'b1111);

        // 3. leading-zero blanking
        load_val(16'h0050, 4'b0000);
        wait_frame(1'b0);
        push_frame(S0, S5, SB, SB, 4'b1111);
        load_val(16'h0A00, 4'b0000);
        wait_frame(1'b0);
        push_frame(S0, S0, SD, SB, 4'b1111);
        load_val(16'h0000, 4'b0100);
        wait_frame(1'b0);
        push_frame(S0, S0, S0, SB, 4'b1011);

        // 4a. two loads mid-frame: the later one wins at the wrap
        tick(5);
        load_val(16'h1111, 4'b0000);
        tick(3);
        load_val(16'h2222, 4'b0000);
        wait_frame(1'b0);
        push_frame(S2, S2, S2, S2, 4'b1111);

        // 4b. load coincident with the wrap tick shows on the next slot
        tick(15);
        load_val(16'h9876, 4'b0000);
        wait_frame(1'b1);
        push_frame(S6, S7, S8, S9, 4'b1111);

        // 5. blank mid-slot, through a wrap, then released (also into guard)
        wait_frame(1'b0);
        tick(5);
        blank = 1'b1;
        for (int k = 7; k <= 18; k++) begin
            tick(1);
            push_now(4'hF, SB, 1'b1, (k == 17), 1'b0);
        end
        blank = 1'b0;
        tick(1);
        push_now(4'b1110, S6, 1'b1, 1'b0, 1'b1);
        blank = 1'b1;
        tick(1);
        push_now(4'hF, SB, 1'b1, 1'b0, 1'b0);
        blank = 1'b0;
        tick(1);
        push_now(4'hF, SB, 1'b1, 1'b0, 1'b0);
        tick(1);
        push_now(4'b1101, S7, 1'b1, 1'b0, 1'b1);

        // 6. reset during digit 2 with a pending load
        tick(3);
        load_val(16'h5555, 4'b0000);
        resetn = 1'b0;
        tick(1);
        push_now(4'hF, SB, 1'b1, 1'b0, 1'b1);
        resetn = 1'b1;
        tick(1);
        push_now(4'b1110, S0, 1'b1, 1'b0, 1'b1);
        push_slot(4'b1101, SB, 1'b1);
        push_slot(4'b1011, SB, 1'b1);
        push_slot(4'b0111, SB, 1'b1);
        wait_frame(1'b0);
        push_frame(S0, SB, SB, SB, 4'b1111);
        wait_frame(1'b0);
        done = 1'b1;
    end

    // Monitor: pops expectations and compares; also checks frame_done spacing
    always @(negedge clock) begin
        exp_t e;
        bit   lit;
        cyc++;
        if (resetn !== 1'b1) have_fd = 1'b0;

        if (resetn === 1'b1 && frame_done === 1'b1) begin
            if (have_fd) begin
                vectors++;
                if (cyc - last_fd != 16) begin
                    errors++;
                    $display("FAIL frame_period: got %0d cycles, expected 16", cyc - last_fd);
                end
            end
            have_fd = 1'b1;
            last_fd = cyc;
        end

        lit = (anodes !== prev_an) && (anodes !== 4'hF);
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (e.kind == K_NOW) begin
                void'(exp_q.pop_front());
                vectors++;
                if (anodes !== e.an || frame_done !== e.fd ||
                    (e.chk_seg && (cathodes !== e.seg || dp_out !== e.dpo))) begin
                    errors++;
                    $display("FAIL now#%0d: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b (seg checked=%b)",
                             e.id, anodes, cathodes, dp_out, frame_done, e.an, e.seg, e.dpo, e.fd, e.chk_seg);
                end
            end else if (lit) begin
                void'(exp_q.pop_front());
                vectors++;
                if (anodes !== e.an || cathodes !== e.seg || dp_out !== e.dpo) begin
                    errors++;
                    $display("FAIL slot#%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                             e.id, anodes, cathodes, dp_out, e.an, e.seg, e.dpo);
                end
                vectors++;
                if (prev_an !== 4'hF) begin
                    errors++;
                    $display("FAIL guard#%0d: anodes before slot %b, expected 1111", e.id, prev_an);
                end
            end
        end
        prev_an = anodes;

        if (done) begin
            vectors++;
            if (exp_q.size() != 0 || timeouts != 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left, %0d frame timeouts, expected 0 and 0",
                         exp_q.size(), timeouts);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
            $finish;
        end else if (cyc > 20000) begin
            vectors++;
            errors++;
            $display("FAIL watchdog: %0d cycles without completion, expected under 20000", cyc);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
            $finish;
        end
    end

endmodule
